if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: a single-outstanding request engine feeding decode
// through an output register and a one-entry skid buffer, with redirect on flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        flush_en,
  input  logic [31:0] branch_target_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_fetchPc;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_discard;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic        r_bufValid;
  logic [31:0] r_bufInstr;
  logic [31:0] r_bufPc;

  logic [31:0] w_target;
  logic [31:0] w_nextPc;
  logic        w_load;
  logic        w_resp;
  logic        w_bufFullNext;

  assign w_target = branch_target_ip & 32'hFFFF_FFFC;
  assign w_nextPc = r_fetchPc + 32'd4;
  assign w_load   = !r_valid || !stall_ip;
  // A response is kept only if it belongs to the current fetch stream.
  assign w_resp   = (r_state == WAIT) && imem_rvalid_ip && !r_discard && !flush_en;
  assign w_bufFullNext = w_load ? (r_bufValid && w_resp) : (r_bufValid || w_resp);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_fetchPc <= RESET_PC;
      r_addr    <= 32'd0;
      r_req     <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush_en) begin
            r_fetchPc <= w_target;
            r_addr    <= w_target;
            r_req     <= 1'b1;
            r_discard <= 1'b0;
            r_state   <= REQ;
          end else if (!r_bufValid) begin
            r_addr  <= r_fetchPc;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          // The pending request still completes with its old address; its data is dropped.
          if (flush_en) begin
            r_fetchPc <= w_target;
            r_discard <= 1'b1;
          end
          if (imem_gnt_ip) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_ip) begin
            if (flush_en) begin
              r_fetchPc <= w_target;
              r_addr    <= w_target;
              r_discard <= 1'b0;
              r_req     <= 1'b1;
              r_state   <= REQ;
            end else if (r_discard) begin
              r_discard <= 1'b0;
              r_addr    <= r_fetchPc;
              r_req     <= 1'b1;
              r_state   <= REQ;
            end else begin
              r_fetchPc <= w_nextPc;
              if (w_bufFullNext) begin
                r_req   <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_addr  <= w_nextPc;
                r_req   <= 1'b1;
                r_state <= REQ;
              end
            end
          end else if (flush_en) begin
            r_fetchPc <= w_target;
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The skid buffer always drains ahead of a newly arriving response to keep order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_pc       <= 32'd0;
      r_pc4      <= 32'd0;
      r_bufValid <= 1'b0;
      r_bufInstr <= 32'd0;
      r_bufPc    <= 32'd0;
    end else if (flush_en) begin
      r_valid    <= 1'b0;
      r_bufValid <= 1'b0;
    end else if (w_load) begin
      if (r_bufValid) begin
        r_valid    <= 1'b1;
        r_instr    <= r_bufInstr;
        r_pc       <= r_bufPc;
        r_pc4      <= r_bufPc + 32'd4;
        r_bufValid <= w_resp;
        if (w_resp) begin
          r_bufInstr <= imem_rdata_ip;
          r_bufPc    <= r_addr;
        end
      end else if (w_resp) begin
        r_valid <= 1'b1;
        r_instr <= imem_rdata_ip;
        r_pc    <= r_addr;
        r_pc4   <= r_addr + 32'd4;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_resp) begin
      r_bufValid <= 1'b1;
      r_bufInstr <= imem_rdata_ip;
      r_bufPc    <= r_addr;
    end
  end

  assign imem_req_op         = r_req;
  assign imem_addr_op        = r_addr;
  assign instr_data_valid_op = r_valid;
  assign instr_data_op       = r_instr;
  assign pc_op               = r_pc;
  assign pc4_op              = r_pc4;

endmodule
